// File: rtl/decouple_fifo_if.sv
// DTI channel bundle: data qualified by valid, accepted by ready.
// The master drives data/valid; the slave drives ready.
interface decouple_fifo_if #(
  parameter int DIN = 16
);
  logic [DIN-1:0] data;
  logic           valid;
  logic           ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/decouple_fifo.sv
// DEPTH-entry elastic buffer on a DTI channel with optional fall-through.
// din.ready comes from registered state only, so no ready path crosses it.
module decouple_fifo #(
  parameter int DIN         = 16,
  parameter int DEPTH       = 2,
  parameter int FALLTHROUGH = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  decouple_fifo_if.slave         din,
  decouple_fifo_if.master        dout,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam bit FT = (FALLTHROUGH != 0);

  // Handshake: a word moves on a rising edge where valid && ready are both 1;
  // once valid is raised, valid and data hold until that edge.
  logic [DIN-1:0] mem [DEPTH];
  logic [PW-1:0]  wr_q, wr_d;
  logic [PW-1:0]  rd_q, rd_d;
  logic [PW-1:0]  count_q, count_d;
  logic           rdy_en_q;

  logic empty, full;
  logic push_hs, pop_hs, bypass, do_push, do_pop;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW-1:0] == rd_q[AW-1:0]) && (wr_q[AW] != rd_q[AW]);

  assign din.ready  = !full && rdy_en_q;
  // Fall-through is gated by the ready-enable so nothing appears on dout in reset.
  assign dout.valid = !empty || (FT && din.valid && rdy_en_q);
  assign dout.data  = (FT && empty) ? din.data : mem[rd_q[AW-1:0]];

  assign push_hs = din.valid && din.ready;
  assign pop_hs  = dout.valid && dout.ready;
  assign bypass  = FT && empty && push_hs && pop_hs;
  assign do_push = push_hs && !bypass;
  assign do_pop  = pop_hs && !bypass && !empty;

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (do_push) wr_d = wr_q + 1'b1;
    if (do_pop)  rd_d = rd_q + 1'b1;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q     <= '0;
      rd_q     <= '0;
      count_q  <= '0;
      rdy_en_q <= 1'b0;
    end else begin
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      count_q  <= count_d;
      rdy_en_q <= 1'b1;
    end
  end

  // Storage carries no reset; only pointer-covered entries are ever read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q[AW-1:0]] <= din.data;
  end

  assign count = count_q;
endmodule
